axi4_to_lite_bridge: RTL and testbench

- Parametrised successor to the fixed 64-to-32 PCIe-side protocol conversion: converts a full AXI4 slave port (bursts, IDs) into single-beat AXI4-Lite master transactions at equal data width.
- Sits between the PCIe AXI master and the register fabric. Independent read and write engines, one outstanding burst each.
- Adds WRAP burst support, sticky worst-case response merging and unsupported-size error handling.

---
 rtl/axi4_to_lite_bridge.sv | 255 +++++++++++++++++++++++++
 tb/tb_axi4_to_lite_bridge.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_to_lite_bridge.sv
// axi4_to_lite_bridge: splits AXI4 bursts into single-beat AXI4-Lite transfers with independent read and write engines
module axi4_to_lite_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_BRESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        len,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] bytes;
        logic [ADDR_W-1:0] mask;
        bytes = ADDR_W'(1) << size;
        mask  = (ADDR_W'(len) + ADDR_W'(1)) * bytes - ADDR_W'(1);
        return burst == 2'b00 ? addr :
               burst == 2'b10 ? (addr & ~mask) | ((addr + bytes) & mask) : addr + bytes;
    endfunction

    function automatic logic [1:0] merge(input logic [1:0] a, input logic [1:0] b);
        return (a == 2'b11 || b == 2'b11) ? 2'b11 :
               (a == 2'b10 || b == 2'b10) ? 2'b10 : 2'b00;
    endfunction

    wr_state_t           r_wstate;
    wr_state_t           w_wstate_nxt;
    logic [ID_W-1:0]     r_wid;
    logic [ADDR_W-1:0]   r_waddr;
    logic [7:0]          r_wlen;
    logic [2:0]          r_wsize;
    logic [1:0]          r_wburst;
    logic [7:0]          r_wbeat;
    logic [1:0]          r_wresp;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_aw_done;
    logic                r_wd_done;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_maw_hs;
    logic                w_mw_hs;
    logic                w_mb_hs;
    logic                w_aw_ok;
    logic                w_wd_ok;
    logic                w_wsize_err;
    logic                w_wlast_beat;
    logic                w_unused;

    assign w_unused      = &{1'b0, s_axi_wlast};
    assign s_axi_awready = !areset && r_wstate == W_IDLE;
    assign s_axi_wready  = !areset && r_wstate == W_DATA;
    assign s_axi_bvalid  = r_wstate == W_BRESP;
    assign s_axi_bid     = r_wid;
    assign s_axi_bresp   = r_wresp;
    assign m_axi_awaddr  = r_waddr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_wstate == W_ADDR && !r_aw_done;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wstate == W_ADDR && !r_wd_done;
    assign m_axi_bready  = !areset && r_wstate == W_RESP;
    assign w_aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_w_hs        = s_axi_wvalid && s_axi_wready;
    assign w_b_hs        = s_axi_bvalid && s_axi_bready;
    assign w_maw_hs      = m_axi_awvalid && m_axi_awready;
    assign w_mw_hs       = m_axi_wvalid && m_axi_wready;
    assign w_mb_hs       = m_axi_bvalid && m_axi_bready;
    assign w_aw_ok       = r_aw_done || w_maw_hs;
    assign w_wd_ok       = r_wd_done || w_mw_hs;
    assign w_wsize_err   = r_wsize > MAX_SIZE;
    assign w_wlast_beat  = r_wbeat == r_wlen;

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs) w_wstate_nxt = !w_wsize_err ? W_ADDR : w_wlast_beat ? W_BRESP : W_DATA;
            W_ADDR:  if (w_aw_ok && w_wd_ok) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_mb_hs) w_wstate_nxt = w_wlast_beat ? W_BRESP : W_DATA;
            W_BRESP: if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wstate  <= W_IDLE;
            r_wid     <= '0;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wsize   <= '0;
            r_wburst  <= '0;
            r_wbeat   <= '0;
            r_wresp   <= 2'b00;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_wd_done <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_aw_hs) begin
                r_wid    <= s_axi_awid;
                r_waddr  <= s_axi_awaddr;
                r_wlen   <= s_axi_awlen;
                r_wsize  <= s_axi_awsize;
                r_wburst <= s_axi_awburst;
                r_wbeat  <= '0;
                r_wresp  <= 2'b00;
            end
            if (w_w_hs) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
            if (r_wstate == W_ADDR) begin
                r_aw_done <= w_aw_ok && !w_wd_ok;
                r_wd_done <= w_wd_ok && !w_aw_ok;
            end
            if (w_mb_hs)
                r_wresp <= merge(r_wresp, m_axi_bresp);
            else if (w_w_hs && w_wsize_err)
                r_wresp <= merge(r_wresp, 2'b10);
            if ((w_mb_hs || (w_w_hs && w_wsize_err)) && !w_wlast_beat) begin
                r_waddr <= next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
                r_wbeat <= r_wbeat + 8'd1;
            end
        end
    end

    rd_state_t           r_rstate;
    rd_state_t           w_rstate_nxt;
    logic [ID_W-1:0]     r_rid;
    logic [ADDR_W-1:0]   r_raddr;
    logic [7:0]          r_rlen;
    logic [2:0]          r_rsize;
    logic [1:0]          r_rburst;
    logic [7:0]          r_rbeat;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic                w_mar_hs;
    logic                w_rsize_err;
    logic                w_rlast_beat;
    logic                w_rdata_st;

    assign w_rdata_st    = r_rstate == R_DATA;
    assign w_rsize_err   = r_rsize > MAX_SIZE;
    assign w_rlast_beat  = r_rbeat == r_rlen;
    assign s_axi_arready = !areset && r_rstate == R_IDLE;
    assign s_axi_rid     = r_rid;
    assign s_axi_rvalid  = w_rdata_st && (w_rsize_err || m_axi_rvalid);
    assign s_axi_rdata   = (w_rdata_st && !w_rsize_err) ? m_axi_rdata : '0;
    assign s_axi_rresp   = !w_rdata_st ? 2'b00 : w_rsize_err ? 2'b10 : m_axi_rresp;
    assign s_axi_rlast   = w_rdata_st && w_rlast_beat;
    assign m_axi_araddr  = r_raddr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_rstate == R_ADDR && !w_rsize_err;
    assign m_axi_rready  = !areset && w_rdata_st && !w_rsize_err && s_axi_rready;
    assign w_ar_hs       = s_axi_arvalid && s_axi_arready;
    assign w_r_hs        = s_axi_rvalid && s_axi_rready;
    assign w_mar_hs      = m_axi_arvalid && m_axi_arready;

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_ADDR;
            R_ADDR:  if (w_rsize_err || w_mar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs) w_rstate_nxt = w_rlast_beat ? R_IDLE : R_ADDR;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rstate <= R_IDLE;
            r_rid    <= '0;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rsize  <= '0;
            r_rburst <= '0;
            r_rbeat  <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_hs) begin
                r_rid    <= s_axi_arid;
                r_raddr  <= s_axi_araddr;
                r_rlen   <= s_axi_arlen;
                r_rsize  <= s_axi_arsize;
                r_rburst <= s_axi_arburst;
                r_rbeat  <= '0;
            end
            if (w_r_hs && !w_rlast_beat) begin
                r_raddr <= next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
                r_rbeat <= r_rbeat + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_axi4_to_lite_bridge.sv
// tb_axi4_to_lite_bridge: directed stimulus, Lite slave model and queue-based scoreboard for the bridge
`timescale 1ns/1ps
module tb_axi4_to_lite_bridge;
    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  s_axi_awid;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    axi4_to_lite_bridge #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    always #5 aclk = ~aclk;

    int n_pass = 0;
    int n_chk = 0;
    int aw_delay = 0;
    int aw_wait = 0;
    logic r_tog = 1'b0;

    logic [31:0] q_aw[$];
    logic [35:0] q_w[$];
    logic [31:0] q_ar[$];
    logic [5:0]  q_b[$];
    logic [38:0] q_r[$];
    logic [1:0]  q_bplan[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s", name);
    endtask

    task automatic chk_quiet(input string name);
        chk({name, " ctrl"}, {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
            s_axi_rlast, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
            s_axi_bresp, s_axi_rresp}, '0);
        chk({name, " addr/id"}, {s_axi_bid, s_axi_rid, m_axi_awaddr, m_axi_araddr}, '0);
    endtask

    // Scoreboard monitor: every handshake seen on an output channel pops one expectation
    initial forever begin
        @(negedge aclk);
        if (!areset) begin
            if (m_axi_awvalid && m_axi_awready) begin
                if (q_aw.size() == 0) fail($sformatf("lite_aw unexpected addr %0h", m_axi_awaddr));
                else chk("lite_aw", {m_axi_awprot, m_axi_awaddr}, {3'b000, q_aw.pop_front()});
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (q_w.size() == 0) fail($sformatf("lite_w unexpected data %0h", m_axi_wdata));
                else chk("lite_w", {m_axi_wdata, m_axi_wstrb}, q_w.pop_front());
            end
            if (m_axi_arvalid && m_axi_arready) begin
                if (q_ar.size() == 0) fail($sformatf("lite_ar unexpected addr %0h", m_axi_araddr));
                else chk("lite_ar", {m_axi_arprot, m_axi_araddr}, {3'b000, q_ar.pop_front()});
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (q_b.size() == 0) fail("s_b unexpected");
                else chk("s_b id/resp", {s_axi_bid, s_axi_bresp}, q_b.pop_front());
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (q_r.size() == 0) fail("s_r unexpected");
                else chk("s_r id/data/resp/last", {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}, q_r.pop_front());
            end
        end
    end

    // Lite slave model: read data is {16'hC0DE, addr[15:0]}, write responses come from q_bplan
    logic sl_aw_hs, sl_w_hs, sl_b_hs, sl_ar_hs, sl_r_hs, sl_awv, got_aw, got_w;
    logic [31:0] sl_araddr;
    initial begin
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        got_aw = 1'b0;
        got_w  = 1'b0;
        forever begin
            @(negedge aclk);
            sl_aw_hs  = m_axi_awvalid && m_axi_awready;
            sl_w_hs   = m_axi_wvalid && m_axi_wready;
            sl_b_hs   = m_axi_bvalid && m_axi_bready;
            sl_ar_hs  = m_axi_arvalid && m_axi_arready;
            sl_r_hs   = m_axi_rvalid && m_axi_rready;
            sl_awv    = m_axi_awvalid;
            sl_araddr = m_axi_araddr;
            @(posedge aclk);
            #1;
            if (areset) begin
                m_axi_bvalid = 1'b0;
                m_axi_rvalid = 1'b0;
                got_aw = 1'b0;
                got_w = 1'b0;
                aw_wait = 0;
            end else begin
                if (sl_b_hs) begin
                    m_axi_bvalid = 1'b0;
                    got_aw = 1'b0;
                    got_w = 1'b0;
                end
                if (sl_aw_hs) got_aw = 1'b1;
                if (sl_w_hs) got_w = 1'b1;
                aw_wait = sl_aw_hs ? 0 : sl_awv ? aw_wait + 1 : aw_wait;
                if (got_aw && got_w && !m_axi_bvalid) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp = q_bplan.size() != 0 ? q_bplan.pop_front() : 2'b00;
                end
                if (sl_r_hs) m_axi_rvalid = 1'b0;
                if (sl_ar_hs) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata = {16'hC0DE, sl_araddr[15:0]};
                    m_axi_rresp = 2'b00;
                end
            end
            m_axi_awready = aw_wait >= aw_delay;
        end
    end

    initial forever begin
        @(posedge aclk);
        #1;
        s_axi_rready = r_tog ? !s_axi_rready : 1'b1;
    end

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        s_axi_awid = id;
        s_axi_awaddr = addr;
        s_axi_awlen = len;
        s_axi_awsize = size;
        s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        do begin @(negedge aclk); n++; end while (!s_axi_awready && n < 200);
        if (!s_axi_awready) fail("aw handshake timeout");
        @(posedge aclk);
        #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        s_axi_wdata = data;
        s_axi_wstrb = strb;
        s_axi_wlast = last;
        s_axi_wvalid = 1'b1;
        do begin @(negedge aclk); n++; end while (!s_axi_wready && n < 200);
        if (!s_axi_wready) fail("w handshake timeout");
        @(posedge aclk);
        #1;
        s_axi_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        s_axi_arid = id;
        s_axi_araddr = addr;
        s_axi_arlen = len;
        s_axi_arsize = size;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        do begin @(negedge aclk); n++; end while (!s_axi_arready && n < 200);
        if (!s_axi_arready) fail("ar handshake timeout");
        @(posedge aclk);
        #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((q_aw.size() + q_w.size() + q_ar.size() + q_b.size() + q_r.size()) != 0 && n < 500) begin
            @(posedge aclk);
            n++;
        end
        if ((q_aw.size() + q_w.size() + q_ar.size() + q_b.size() + q_r.size()) != 0) begin
            fail({name, " drain timeout"});
            q_aw.delete(); q_w.delete(); q_ar.delete(); q_b.delete(); q_r.delete();
        end
        repeat (3) @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
        s_axi_arvalid = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk_quiet("reset");
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("idle readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b101);
        @(posedge aclk);
        #1;

        q_aw.push_back(32'h100);
        q_w.push_back({32'hDEADBEEF, 4'hF});
        q_b.push_back({4'h3, 2'b00});
        send_aw(4'h3, 32'h100, 8'd0, 3'd2, 2'b01);
        send_w(32'hDEADBEEF, 4'hF, 1'b1);
        wait_drain("single write");

        foreach (q_ar[i]) q_ar.delete(i);
        q_ar = '{32'h200, 32'h204, 32'h208, 32'h20C};
        q_r = '{{4'h5, 32'hC0DE0200, 2'b00, 1'b0}, {4'h5, 32'hC0DE0204, 2'b00, 1'b0},
                {4'h5, 32'hC0DE0208, 2'b00, 1'b0}, {4'h5, 32'hC0DE020C, 2'b00, 1'b1}};
        send_ar(4'h5, 32'h200, 8'd3, 3'd2, 2'b01);
        wait_drain("incr read");

        q_ar = '{32'h38, 32'h3C, 32'h30, 32'h34};
        q_r = '{{4'h6, 32'hC0DE0038, 2'b00, 1'b0}, {4'h6, 32'hC0DE003C, 2'b00, 1'b0},
                {4'h6, 32'hC0DE0030, 2'b00, 1'b0}, {4'h6, 32'hC0DE0034, 2'b00, 1'b1}};
        send_ar(4'h6, 32'h38, 8'd3, 3'd2, 2'b10);
        wait_drain("wrap read");

        q_bplan = '{2'b00, 2'b10, 2'b11, 2'b00};
        q_aw = '{32'h400, 32'h404, 32'h408, 32'h40C};
        q_w = '{{32'h11111111, 4'hF}, {32'h22222222, 4'hF}, {32'h33333333, 4'hF}, {32'h44444444, 4'hF}};
        q_b.push_back({4'h7, 2'b11});
        send_aw(4'h7, 32'h400, 8'd3, 3'd2, 2'b01);
        send_w(32'h11111111, 4'hF, 1'b0);
        send_w(32'h22222222, 4'hF, 1'b0);
        send_w(32'h33333333, 4'hF, 1'b0);
        send_w(32'h44444444, 4'hF, 1'b1);
        wait_drain("error merge");

        aw_delay = 3;
        r_tog = 1'b1;
        q_bplan = '{2'b01, 2'b00};
        q_aw = '{32'h500, 32'h504};
        q_w = '{{32'hAAAA0001, 4'h3}, {32'hAAAA0002, 4'hC}};
        q_b.push_back({4'h9, 2'b00});
        q_ar = '{32'h600, 32'h600, 32'h600};
        q_r = '{{4'hA, 32'hC0DE0600, 2'b00, 1'b0}, {4'hA, 32'hC0DE0600, 2'b00, 1'b0},
                {4'hA, 32'hC0DE0600, 2'b00, 1'b1}};
        fork
            begin
                send_aw(4'h9, 32'h500, 8'd1, 3'd2, 2'b01);
                send_w(32'hAAAA0001, 4'h3, 1'b0);
                send_w(32'hAAAA0002, 4'hC, 1'b1);
            end
            send_ar(4'hA, 32'h600, 8'd2, 3'd2, 2'b00);
        join
        wait_drain("backpressure");
        aw_delay = 0;
        r_tog = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        q_aw.push_back(32'h700);
        q_w.push_back({32'h5A5A0001, 4'hF});
        send_aw(4'h2, 32'h700, 8'd3, 3'd2, 2'b01);
        send_w(32'h5A5A0001, 4'hF, 1'b0);
        wait_drain("pre-reset beat");
        repeat (4) @(posedge aclk);
        #1;
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk_quiet("mid-burst reset");
        @(posedge aclk);
        #1;
        areset = 1'b0;
        q_aw.push_back(32'h800);
        q_w.push_back({32'h12345678, 4'hF});
        q_b.push_back({4'h1, 2'b00});
        send_aw(4'h1, 32'h800, 8'd0, 3'd2, 2'b01);
        send_w(32'h12345678, 4'hF, 1'b1);
        wait_drain("post-reset write");

        q_r = '{{4'hC, 32'h0, 2'b10, 1'b0}, {4'hC, 32'h0, 2'b10, 1'b1}};
        send_ar(4'hC, 32'h900, 8'd1, 3'd3, 2'b01);
        wait_drain("size error read");

        q_b.push_back({4'hD, 2'b10});
        send_aw(4'hD, 32'hA00, 8'd1, 3'd3, 2'b01);
        send_w(32'hBBBB0001, 4'hF, 1'b0);
        send_w(32'hBBBB0002, 4'hF, 1'b1);
        wait_drain("size error write");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
